apb_slave_regbank: RTL
======================

Name: apb_slave_regbank

Overview:
- APB slave register bank sitting directly downstream of the AHB-to-APB bridge; consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA.
- NUM_REGS word registers: NUM_REGS-1 read/write, plus one read-only write counter at the top index.
- Programmable wait-state insertion via PREADY. The AHB-to-APB bridge ignores PREADY, so instances behind it use WAIT_CYCLES = 0.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, register and data width.
- NUM_REGS, 16, number of word registers (>= 2, power of 2). Index NUM_REGS-1 is WCNT, read-only.
- WAIT_CYCLES, 0, wait states inserted in every access phase (0..255).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset: synchronous, active-high
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PADDR  in  ADDR_WIDTH  byte address; word index = PADDR[log2(NUM_REGS)+1:2]; PADDR[1:0] ignored
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - state = IDLE, wait counter = 0, all registers including WCNT = 0.
  - Any write whose completing edge coincides with reset is discarded.
- Outputs after reset: PREADY=0, PSLVERR=0, PRDATA=0.
- Setup cycle = PSEL & ~PENABLE. Access cycle = PSEL & PENABLE.
- State machine (registered state, 8-bit down-counter cnt):
  - IDLE: on a setup cycle, cnt <= WAIT_CYCLES. Go to DONE if WAIT_CYCLES == 0, else WAIT. Otherwise stay in IDLE.
  - WAIT: if ~PSEL (aborted transfer), go to IDLE with no commit. Else cnt decrements; when cnt == 1, go to DONE.
  - DONE: this is the completion cycle. Next state:
    - setup cycle present (back-to-back): reload as in IDLE;
    - otherwise: IDLE.
- PREADY = (state == DONE) & PSEL & PENABLE, combinational from the registered state.
- Latency: setup at cycle T gives PREADY=1 at cycle T+1+WAIT_CYCLES. With WAIT_CYCLES=0, PREADY is high in the first access cycle.
- Out-of-range: PADDR[ADDR_WIDTH-1:2] >= NUM_REGS. Full word index is compared; no base address, since decoding is done upstream.
- Write commit happens at the PCLK edge ending a cycle with PREADY=1 & PWRITE:
  - in-range, index < NUM_REGS-1: reg[idx] <= PWDATA, and WCNT <= WCNT+1.
  - WCNT wraps from all-ones to 0.
  - write to WCNT or out-of-range: no register change, WCNT unchanged.
- PRDATA, combinational:
  - reg[idx] when PSEL & ~PWRITE & in-range;
  - otherwise 0.
  - Stable throughout the access phase, valid whenever PREADY=1.
- Simultaneous events:
  - A write to reg k and a read of WCNT in the following transfer returns the incremented value.
  - Back-to-back transfers (DONE followed directly by setup) have no idle gap.
- PSLVERR: 0 unless APB_SLVERR_EN.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined:
  - PSLVERR = PREADY & (out-of-range | (PWRITE & idx == NUM_REGS-1)).
  - Out-of-range reads return 0 with PSLVERR=1.
  - Errored writes never commit.
- Undefined:
  - PSLVERR is tied to 0.
  - Errored writes are silently dropped; out-of-range reads return 0.

Test Plan:
- Reset, then read idx 0..15 (PADDR 0x00..0x3C) -> PRDATA=0x0 for all; PREADY high in the first access cycle (WAIT_CYCLES=0).
- Write 0xDEADBEEF to 0x08, then read 0x08 and 0x3C -> 0xDEADBEEF and WCNT=1. Back-to-back write 0x00000001 to 0x04 then read 0x04 with no idle cycle -> 0x00000001, WCNT=2.
- WAIT_CYCLES=3: setup at T -> PREADY=0 at T+1..T+3, PREADY=1 at T+4. Drop PSEL at T+2 -> return to IDLE, register unchanged.
- Preload WCNT to 0xFFFFFFFF via 2^32-1 writes (or force in bench), then write 0x10 -> WCNT=0x00000000.
- APB_SLVERR_EN: write 0x55 to 0x40 (out-of-range) and to 0x3C (WCNT) -> PSLVERR=1 with PREADY, no register or WCNT change. Without the macro -> PSLVERR=0, same data results.
- Assert PRESET in the DONE cycle of a write of 0xA5A5A5A5 to 0x00 -> register reads back 0x0, WCNT=0, PREADY=0 next cycle.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with programmable wait states.
// NUM_REGS-1 read/write word registers plus a read-only write counter (WCNT)
// at the top index. Define APB_SLVERR_EN to drive PSLVERR on out-of-range
// accesses and on writes to WCNT; otherwise PSLVERR is tied low.
module apb_slave_regbank #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned IdxW     = $clog2(NUM_REGS);
    localparam logic [IdxW-1:0] WcntIdx  = IdxW'(NUM_REGS - 1);
    localparam logic [7:0]      WaitInit = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic                  setup;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic [IdxW-1:0]       idx;
    logic                  in_range;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
    logic [DATA_WIDTH-1:0] wcnt_q;
    logic                  unused_addr;

    assign setup       = PSEL & ~PENABLE;
    assign word_addr   = PADDR[ADDR_WIDTH-1:2];
    assign idx         = PADDR[IdxW+1:2];
    // Full word index is compared, so aliases above the bank are rejected.
    assign in_range    = word_addr < (ADDR_WIDTH-2)'(NUM_REGS);
    assign unused_addr = ^PADDR[1:0];

    // State register and wait counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: reload on setup, count down wait states, abort on PSEL drop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (setup) begin
                    cnt_d   = WaitInit;
                    state_d = (WAIT_CYCLES == 0) ? StDone : StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completion handshake, decoded from the registered state.
    always_comb begin
        PREADY = (state_q == StDone) & PSEL & PENABLE;
`ifdef APB_SLVERR_EN
        PSLVERR = PREADY & (~in_range | (PWRITE & (idx == WcntIdx)));
`else
        PSLVERR = 1'b0;
`endif
    end

    // Writes to WCNT or outside the bank never commit.
    assign wr_en = PREADY & PWRITE & in_range & (idx != WcntIdx);

    // Register file and write counter; reset discards a coinciding write.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
            wcnt_q <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (idx == IdxW'(i)) regs_q[i] <= PWDATA;
            end
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    // Read mux: WCNT at the top index, zero for writes and out-of-range reads.
    always_comb begin
        rd_word = wcnt_q;
        for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (idx == IdxW'(i)) rd_word = regs_q[i];
        end
        PRDATA = (PSEL & ~PWRITE & in_range) ? rd_word : '0;
    end

endmodule
